// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default bit timing,
// common to the receiver and the board's transmitter.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] START      = 3'd1;
    localparam logic [2:0] DATA       = 3'd2;
    localparam logic [2:0] STOP       = 3'd3;
    localparam logic [2:0] CLEANUP    = 3'd4;
    localparam logic [2:0] BREAK_WAIT = 3'd5;

endpackage

// File: rtl/uart_receiver_if.sv
// Receive-side UART bundle: serial line in, byte and status pulses out.
// The slave modport is the receiver, the master is the line driver / consumer.
interface uart_receiver_if;

    logic       rx_serial;
    logic [7:0] rx_byte;
    logic       rx_data_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    modport master (
        output rx_serial,
        input  rx_byte,
        input  rx_data_valid,
        input  rx_frame_err,
        input  rx_busy
    );

    modport slave (
        input  rx_serial,
        output rx_byte,
        output rx_data_valid,
        output rx_frame_err,
        output rx_busy
    );

endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value
// is chosen so the synced line matches the idle level of the source.
module uart_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversamples the synchronized line, samples each bit
// mid-period (LSB first) and reports good bytes or framing errors as pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic            CLOCK,
    input  logic            RESET,
    uart_receiver_if.slave  rx
);

    localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic [7:0]       rx_byte_r;
    logic             data_valid_r;
    logic             frame_err_r;
    logic             busy_r;

    uart_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .d     (rx.rx_serial),
        .q     (rx_s)
    );

    // busy is registered alongside each state change so it tracks "not IDLE"
    // without a combinational decode on the output.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            rx_byte_r    <= 8'h00;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    busy_r <= 1'b0;
                    cnt    <= '0;
                    if (!rx_s) begin
                        state  <= START;
                        busy_r <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt                <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_byte_r    <= shift_reg;
                            data_valid_r <= 1'b1;
                            state        <= CLEANUP;
                        end else begin
                            frame_err_r <= 1'b1;
                            state       <= BREAK_WAIT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CLEANUP: begin
                    bit_idx <= '0;
                    cnt     <= '0;
                    state   <= IDLE;
                    busy_r  <= 1'b0;
                end
                BREAK_WAIT: begin
                    // A held-low line (break) must see a high before re-arming.
                    busy_r  <= 1'b1;
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    bit_idx <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign rx.rx_byte       = rx_byte_r;
    assign rx.rx_data_valid = data_valid_r;
    assign rx.rx_frame_err  = frame_err_r;
    assign rx.rx_busy       = busy_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: a bit-accurate serial driver pushes
// expected bytes, a negedge monitor pops and compares on each valid pulse.
module tb_uart_receiver;

    localparam int CPB      = 434;
    localparam int HALF     = (CPB - 1) / 2;
    localparam int LAT_EXP  = HALF + 9 * CPB + 1 + 2;

    logic clk;
    logic rst;
    int   cyc;

    int n_cmp;
    int n_bad;
    int n_valid;
    int n_ferr;
    int valid_cyc;

    logic [7:0] exp_q[$];

    uart_receiver_if bus ();

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .CLOCK (clk),
        .RESET (rst),
        .rx    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard side: compare each delivered byte with the oldest sent one.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_data_valid || bus.rx_frame_err)
                chk("vld_ferr_excl", {31'd0, bus.rx_data_valid & bus.rx_frame_err}, 32'd0);
            if (bus.rx_data_valid) begin
                n_valid++;
                valid_cyc = cyc;
                chk("queue_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0)
                    chk("rx_byte", {24'd0, bus.rx_byte}, {24'd0, exp_q.pop_front()});
            end
            if (bus.rx_frame_err) n_ferr++;
        end
    end

    // Drives one 8N1 frame at the given bit period; max_cyc > 0 truncates it.
    task automatic send_frame(input logic [7:0] b, input int period,
                              input logic stop_v, input int max_cyc);
        logic [9:0] fr;
        int n;
        fr = {stop_v, b, 1'b0};
        n  = 0;
        for (int i = 0; i < 10; i++) begin
            bus.rx_serial = fr[i];
            for (int c = 0; c < period; c++) begin
                if (max_cyc > 0 && n >= max_cyc) return;
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic send_good(input logic [7:0] b, input int period);
        exp_q.push_back(b);
        send_frame(b, period, 1'b1, 0);
    endtask

    initial begin
        int v0, f0, t0, lat;
        logic [7:0] pat[4];
        pat[0] = 8'h53; pat[1] = 8'h4D; pat[2] = 8'h01; pat[3] = 8'h08;
        n_cmp = 0; n_bad = 0; n_valid = 0; n_ferr = 0; valid_cyc = 0; cyc = 0;
        rst = 1'b1;
        bus.rx_serial = 1'b1;
        #1;
        chk("rst_byte", {24'd0, bus.rx_byte}, 32'h00);
        chk("rst_vld", {31'd0, bus.rx_data_valid}, 32'd0);
        chk("rst_ferr", {31'd0, bus.rx_frame_err}, 32'd0);
        chk("rst_busy", {31'd0, bus.rx_busy}, 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 1: single frame with latency
        v0 = n_valid; f0 = n_ferr; t0 = cyc;
        send_good(8'h53, CPB);
        repeat (10) @(negedge clk);
        lat = valid_cyc - t0;
        chk("t1_vld_cnt", n_valid - v0, 1);
        chk("t1_ferr_cnt", n_ferr - f0, 0);
        chk("t1_byte_held", {24'd0, bus.rx_byte}, 32'h53);
        chk("t1_busy", {31'd0, bus.rx_busy}, 32'd0);
        chk("t1_latency_ok", {31'd0, (lat >= LAT_EXP - 2) && (lat <= LAT_EXP + 2)}, 32'd1);

        // 2: back-to-back, zero idle gap
        v0 = n_valid; f0 = n_ferr;
        for (int i = 0; i < 4; i++) send_good(pat[i], CPB);
        repeat (10) @(negedge clk);
        chk("t2_vld_cnt", n_valid - v0, 4);
        chk("t2_ferr_cnt", n_ferr - f0, 0);
        chk("t2_drain", exp_q.size(), 0);

        // 3: 100-cycle low glitch on idle line
        v0 = n_valid; f0 = n_ferr;
        bus.rx_serial = 1'b0;
        repeat (100) @(negedge clk);
        bus.rx_serial = 1'b1;
        chk("t3_busy_on", {31'd0, bus.rx_busy}, 32'd1);
        repeat (140) @(negedge clk);
        chk("t3_busy_off", {31'd0, bus.rx_busy}, 32'd0);
        chk("t3_vld_cnt", n_valid - v0, 0);
        chk("t3_ferr_cnt", n_ferr - f0, 0);

        // 4: bad stop bit, long break, then recovery
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'hA5, CPB, 1'b0, 0);
        repeat (5000) @(negedge clk);
        chk("t4_ferr_cnt", n_ferr - f0, 1);
        chk("t4_vld_cnt", n_valid - v0, 0);
        chk("t4_byte_kept", {24'd0, bus.rx_byte}, 32'h08);
        chk("t4_busy_break", {31'd0, bus.rx_busy}, 32'd1);
        bus.rx_serial = 1'b1;
        repeat (10) @(negedge clk);
        chk("t4_busy_idle", {31'd0, bus.rx_busy}, 32'd0);
        send_good(8'h3C, CPB);
        repeat (10) @(negedge clk);
        chk("t4_vld_after", n_valid - v0, 1);
        chk("t4_byte_new", {24'd0, bus.rx_byte}, 32'h3C);

        // 5: reset in the middle of bit 4
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'hFF, CPB, 1'b1, 5 * CPB + 200);
        chk("t5_busy_pre", {31'd0, bus.rx_busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_byte", {24'd0, bus.rx_byte}, 32'h00);
        chk("t5_rst_busy", {31'd0, bus.rx_busy}, 32'd0);
        chk("t5_rst_vld", {31'd0, bus.rx_data_valid}, 32'd0);
        bus.rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        send_good(8'h81, CPB);
        repeat (10) @(negedge clk);
        chk("t5_vld_cnt", n_valid - v0, 1);
        chk("t5_ferr_cnt", n_ferr - f0, 0);

        // 6: sender clock off by about +-2%
        v0 = n_valid; f0 = n_ferr;
        send_good(8'h00, 425);
        send_good(8'hFF, 425);
        send_good(8'h00, 443);
        send_good(8'hFF, 443);
        repeat (20) @(negedge clk);
        chk("t6_vld_cnt", n_valid - v0, 4);
        chk("t6_ferr_cnt", n_ferr - f0, 0);
        chk("t6_drain", exp_q.size(), 0);
        chk("t6_busy", {31'd0, bus.rx_busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
